pc_control: RTL and testbench
=============================

Name: pc_control

Overview:
- Execute-stage neighbour that consumes the ALU result and the ALU overflow indication for the 16-bit CPU.
- Holds the program counter, the Z/V/N flag register and the run/halt state.
- Evaluates B and BR conditions against the flags and selects the next PC.
- Supplies PC and PC+2 to fetch, and PC+2 to writeback for PCS.
- Sits between the ALU output and instruction fetch, in a single-cycle datapath.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance; when 1 the instruction on the inputs retires this cycle.
- opcode  in  4  current instruction opcode (0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LW, 9 SW, A LLB, B LHB, C B, D BR, E PCS, F HLT).
- ccc  in  3  branch condition field.
- imm9  in  9  signed branch offset in instruction words.
- br_target  in  16  register value for BR.
- alu_out  in  16  ALU result.
- alu_ovfl  in  1  ALU signed overflow, meaningful for ADD/SUB.
- pc  out  16  current PC, the fetch address.
- pc_plus2  out  16  pc+2, combinational, for PCS writeback.
- flags  out  3  {Z,V,N} register.
- taken  out  1  combinational; 1 when the current B/BR condition is true.
- halted  out  1  registered; 1 in the HALT state.

Behaviour:
- Reset (async, rst_n=0):
  - pc=PC_RESET, flags=3'b000, state=RUN, halted=0.
  - Release is sampled on the next clk edge.
- States: RUN, HALT.
  - RUN → HALT on an edge with en=1 and opcode=F.
  - HALT exits only via reset.
  - In HALT, en is ignored and pc and flags hold.
- en=0 in RUN: pc, flags and state all hold.
- Next PC in RUN with en=1:
  - B, taken: pc+2+{sext(imm9),1'b0}.
  - BR, taken: br_target. Bit 0 passes through unmodified.
  - B or BR not taken: pc+2.
  - HLT: pc holds, so pc stays at the HLT address.
  - All other opcodes: pc+2.
  - All PC arithmetic is modulo 2^16 and wraps silently: FFFE+2=0000, and negative offsets wrap below 0000.
- Condition codes, evaluated on the current flag register (before any update):
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 or N=0.
  - 101 LTE: Z=1 or N=1.
  - 110 OVFL: V=1.
  - 111 unconditional.
- taken=0 for opcodes other than C and D, and 0 in HALT.
- Flag update, on the edge with en=1 in RUN only:
  - ADD, SUB: Z=(alu_out==0), N=alu_out[15], V=alu_ovfl.
  - XOR, SLL, SRA, ROR: Z=(alu_out==0); V and N hold.
  - All other opcodes: no flag change.
  - A branch never reads flags written by the same instruction, because one instruction retires per cycle.
- Latency:
  - pc and flags update one edge after the instruction is presented.
  - halted rises one edge after HLT is accepted.
- Reset mid-operation, including while in HALT: immediate return to the reset values. Registered outputs change asynchronously with rst_n.

Optional Feature:
- Macro: PC_CONTROL_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt, 32 bits, reset to 0.
  - Increments by 1 on every edge with en=1 in RUN. The HLT instruction itself is counted once.
  - Holds in HALT and wraps at 2^32.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset then release, en=1, four ADDs with alu_out=1 → pc 0000,0002,0004,0006,0008; flags=3'b000 after the last.
- SUB with alu_out=0000, alu_ovfl=0, then B ccc=001 imm9=9'h1F8 at pc=0020 → flags Z=1, taken=1, next pc=0012.
- ADD with alu_out=8000, alu_ovfl=1 → flags=3'b011. Then XOR with alu_out=0000 → flags=3'b111. Then B ccc=110 → taken=1; B ccc=000 → taken=0, pc+2.
- BR ccc=111 br_target=1234 → pc=1234. Then en=0 for 3 cycles → pc stays 1234 and flags are unchanged.
- HLT at pc=0040 → halted=1 one edge later, pc=0040. With en=1 for 5 further cycles → pc, flags and retire_cnt (if enabled) frozen. Then rst_n pulse → pc=PC_RESET, halted=0 immediately.
- pc=FFFE with an ADD → pc wraps to 0000. With the macro enabled, retire_cnt preset near FFFFFFFF wraps to 00000000.

Source files
------------

// File: rtl/pc_control_if.sv
// pc_control_if: instruction-retire bus between execute, fetch and the PC/flag block.
// The pc_control block drives pc, pc_plus2, flags, taken, halted and state_dbg; the
// execute side drives everything else.
// Optional feature macro: PC_CONTROL_RETIRE_CNT_EN adds the 32-bit retire_cnt signal.
//
// Handshake: there is no ready path. When en=1 in the RUN state, the instruction on
// the inputs retires on that rising clock edge. In HALT, en is ignored.
interface pc_control_if;
  logic        en;
  logic [3:0]  opcode;
  logic [2:0]  ccc;
  logic [8:0]  imm9;
  logic [15:0] br_target;
  logic [15:0] alu_out;
  logic        alu_ovfl;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [2:0]  flags;
  logic        taken;
  logic        halted;
  logic        state_dbg;
`ifdef PC_CONTROL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;

  modport master (
    output en, opcode, ccc, imm9, br_target, alu_out, alu_ovfl,
    input  pc, pc_plus2, flags, taken, halted, state_dbg, retire_cnt
  );

  modport slave (
    input  en, opcode, ccc, imm9, br_target, alu_out, alu_ovfl,
    output pc, pc_plus2, flags, taken, halted, state_dbg, retire_cnt
  );
`else
  modport master (
    output en, opcode, ccc, imm9, br_target, alu_out, alu_ovfl,
    input  pc, pc_plus2, flags, taken, halted, state_dbg
  );

  modport slave (
    input  en, opcode, ccc, imm9, br_target, alu_out, alu_ovfl,
    output pc, pc_plus2, flags, taken, halted, state_dbg
  );
`endif
endinterface

// File: rtl/pc_control.sv
// pc_control: program counter, {Z,V,N} flag register and the run/halt state of the
// 16-bit single-cycle CPU. It evaluates B/BR conditions and selects the next PC.
// Optional feature macro: PC_CONTROL_RETIRE_CNT_EN adds a 32-bit retired-instruction
// counter on bus.retire_cnt.
module pc_control #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_control_if.slave   bus
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic [2:0]  r_flags;
  logic [2:0]  w_flags_nxt;

  logic        w_z;
  logic        w_v;
  logic        w_n;
  logic        w_cond_true;
  logic        w_is_branch;
  logic        w_retire;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_b_offset;
  logic [15:0] w_b_target;

  // Flag register layout is {Z,V,N}.
  assign w_z = r_flags[2];
  assign w_v = r_flags[1];
  assign w_n = r_flags[0];

  // An instruction retires only when presented with en=1 while running.
  assign w_retire = (r_state == ST_RUN) && bus.en;

  // PC arithmetic is 16-bit and wraps silently.
  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_b_offset = {{6{bus.imm9[8]}}, bus.imm9, 1'b0};
  assign w_b_target = w_pc_plus2 + w_b_offset;

  assign w_is_branch = (bus.opcode == OP_B) || (bus.opcode == OP_BR);

  // Condition decode against the flags as they stand before this instruction.
  always_comb begin
    w_cond_true = 1'b0;
    unique case (bus.ccc)
      3'b000:  w_cond_true = ~w_z;
      3'b001:  w_cond_true = w_z;
      3'b010:  w_cond_true = ~w_z & ~w_n;
      3'b011:  w_cond_true = w_n;
      3'b100:  w_cond_true = w_z | ~w_n;
      3'b101:  w_cond_true = w_z | w_n;
      3'b110:  w_cond_true = w_v;
      3'b111:  w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Run/halt FSM next state and next PC; HALT is left only through reset.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      ST_RUN: begin
        if (bus.en) begin
          unique case (bus.opcode)
            OP_B:    w_pc_nxt = w_cond_true ? w_b_target : w_pc_plus2;
            OP_BR:   w_pc_nxt = w_cond_true ? bus.br_target : w_pc_plus2;
            OP_HLT:  begin
              w_state_nxt = ST_HALT;
              w_pc_nxt    = r_pc;
            end
            default: w_pc_nxt = w_pc_plus2;
          endcase
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
        w_pc_nxt    = r_pc;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_pc_nxt    = r_pc;
      end
    endcase
  end

  // Next flag value: arithmetic ops set all three, logical/shift ops set Z only.
  always_comb begin
    w_flags_nxt = r_flags;
    if (w_retire) begin
      unique case (bus.opcode)
        OP_ADD, OP_SUB: begin
          w_flags_nxt[2] = (bus.alu_out == 16'h0000);
          w_flags_nxt[1] = bus.alu_ovfl;
          w_flags_nxt[0] = bus.alu_out[15];
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
          w_flags_nxt[2] = (bus.alu_out == 16'h0000);
        end
        default: w_flags_nxt = r_flags;
      endcase
    end
  end

  // State, PC and flag registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= PC_RESET;
      r_flags <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flags <= w_flags_nxt;
    end
  end

`ifdef PC_CONTROL_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Retired-instruction counter; the HLT itself counts once, then the count freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= 32'd0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign bus.retire_cnt = r_retire_cnt;
`endif

  assign bus.pc        = r_pc;
  assign bus.pc_plus2  = w_pc_plus2;
  assign bus.flags     = r_flags;
  assign bus.taken     = (r_state == ST_RUN) && w_is_branch && w_cond_true;
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: directed checks of PC sequencing, branch conditions, flag updates,
// halt behaviour, asynchronous reset and PC wrap for pc_control.
`timescale 1ns/100ps
module tb_pc_control;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  pc_control_if bus ();

  pc_control #(.PC_RESET(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver
  task automatic drive(input logic en, input logic [3:0] op, input logic [2:0] c,
                       input logic [8:0] im, input logic [15:0] bt,
                       input logic [15:0] alu, input logic ov);
    bus.en        = en;
    bus.opcode    = op;
    bus.ccc       = c;
    bus.imm9      = im;
    bus.br_target = bt;
    bus.alu_out   = alu;
    bus.alu_ovfl  = ov;
  endtask

  // Scoreboard helpers
  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Sweep all eight conditions with en=0; exp[i] is the required taken for ccc=i.
  task automatic cond_sweep(input string tag, input logic [3:0] op, input logic [7:0] exp);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, op, 3'(i), 9'h000, 16'h0000, 16'h0000, 1'b0);
      #0.5;
      chk1(tag, bus.taken, exp[i]);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    drive(1'b0, 4'h0, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk16("rst_pc", bus.pc, 16'h0000);
    chk3("rst_flags", bus.flags, 3'b000);
    chk1("rst_halted", bus.halted, 1'b0);
    chk16("rst_pc_plus2", bus.pc_plus2, 16'h0002);
    chk1("rst_taken_add", bus.taken, 1'b0);
`ifdef PC_CONTROL_RETIRE_CNT_EN
    chk16("rst_retire_lo", bus.retire_cnt[15:0], 16'h0000);
`endif
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk16("post_rel_pc", bus.pc, 16'h0000);

    // Conditions on flags=000, then BR sees the same decode
    cond_sweep("cond_b_f000", 4'hC, 8'b1001_0101);
    cond_sweep("cond_br_f000", 4'hD, 8'b1001_0101);
    cond_sweep("cond_add_none", 4'h0, 8'b0000_0000);

    // Four ADDs with alu_out=1
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'h0, 3'b000, 9'h000, 16'h0000, 16'h0001, 1'b0);
      tick();
      chk16("add_pc", bus.pc, 16'(2 * (k + 1)));
    end
    chk3("add_flags", bus.flags, 3'b000);
    chk16("add_pc_plus2", bus.pc_plus2, 16'h000A);
`ifdef PC_CONTROL_RETIRE_CNT_EN
    chk16("retire_after_add", bus.retire_cnt[15:0], 16'h0004);
`endif

    // LW x11 leaves flags alone even with a zero alu_out: pc 0008 -> 001E
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, 4'h8, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0);
      tick();
    end
    chk16("lw_pc", bus.pc, 16'h001E);
    chk3("lw_flags", bus.flags, 3'b000);

    // SUB to zero then B EQ -8 words at 0020
    drive(1'b1, 4'h1, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0);
    tick();
    chk16("sub_pc", bus.pc, 16'h0020);
    chk3("sub_flags", bus.flags, 3'b100);
    drive(1'b1, 4'hC, 3'b001, 9'h1F8, 16'h0000, 16'h0000, 1'b0);
    #0.5;
    chk1("beq_taken", bus.taken, 1'b1);
    tick();
    chk16("beq_pc", bus.pc, 16'h0012);

    // ADD 8000 with overflow -> Z=0 V=1 N=1
    drive(1'b1, 4'h0, 3'b000, 9'h000, 16'h0000, 16'h8000, 1'b1);
    tick();
    chk16("addv_pc", bus.pc, 16'h0014);
    chk3("addv_flags", bus.flags, 3'b011);
    cond_sweep("cond_f011", 4'hC, 8'b1110_1001);

    // XOR zero -> Z set, V/N held
    drive(1'b1, 4'h2, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0);
    tick();
    chk16("xor_pc", bus.pc, 16'h0016);
    chk3("xor_flags", bus.flags, 3'b111);
    cond_sweep("cond_f111", 4'hC, 8'b1111_1010);

    drive(1'b1, 4'hC, 3'b110, 9'h004, 16'h0000, 16'h0000, 1'b0);
    #0.5;
    chk1("bovfl_taken", bus.taken, 1'b1);
    tick();
    chk16("bovfl_pc", bus.pc, 16'h0020);
    drive(1'b1, 4'hC, 3'b000, 9'h004, 16'h0000, 16'h0000, 1'b0);
    #0.5;
    chk1("bne_taken", bus.taken, 1'b0);
    tick();
    chk16("bne_pc", bus.pc, 16'h0022);

    // BR unconditional, then en=0 holds everything
    drive(1'b1, 4'hD, 3'b111, 9'h000, 16'h1234, 16'h0000, 1'b0);
    tick();
    chk16("br_pc", bus.pc, 16'h1234);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'h0, 3'b111, 9'h000, 16'h0000, 16'h0000, 1'b1);
      tick();
      chk16("idle_pc", bus.pc, 16'h1234);
      chk3("idle_flags", bus.flags, 3'b111);
    end

    // Z-only ops and a no-flag op
    drive(1'b1, 4'h4, 3'b000, 9'h000, 16'h0000, 16'h0005, 1'b0);
    tick();
    chk16("sll_pc", bus.pc, 16'h1236);
    chk3("sll_flags", bus.flags, 3'b011);
    drive(1'b1, 4'hA, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0);
    tick();
    chk16("llb_pc", bus.pc, 16'h1238);
    chk3("llb_flags", bus.flags, 3'b011);
    drive(1'b1, 4'h5, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0);
    tick();
    chk3("sra_flags", bus.flags, 3'b111);
    drive(1'b1, 4'h6, 3'b000, 9'h000, 16'h0000, 16'h0001, 1'b0);
    tick();
    chk16("ror_pc", bus.pc, 16'h123C);
    chk3("ror_flags", bus.flags, 3'b011);

    // BR NE taken to an odd target; BR EQ not taken
    drive(1'b1, 4'hD, 3'b000, 9'h000, 16'h1235, 16'h0000, 1'b0);
    tick();
    chk16("br_odd_pc", bus.pc, 16'h1235);
    drive(1'b1, 4'hD, 3'b001, 9'h000, 16'h0000, 16'h0000, 1'b0);
    tick();
    chk16("br_nt_pc", bus.pc, 16'h1237);

    // HLT at 0040
    drive(1'b1, 4'hD, 3'b111, 9'h000, 16'h0040, 16'h0000, 1'b0);
    tick();
    chk16("br40_pc", bus.pc, 16'h0040);
    drive(1'b1, 4'hF, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0);
    #0.5;
    chk1("hlt_pre_halted", bus.halted, 1'b0);
    tick();
    chk1("hlt_halted", bus.halted, 1'b1);
    chk16("hlt_pc", bus.pc, 16'h0040);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'h0, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b1);
      tick();
      chk16("halt_pc", bus.pc, 16'h0040);
      chk3("halt_flags", bus.flags, 3'b011);
      chk1("halt_halted", bus.halted, 1'b1);
    end
    drive(1'b1, 4'hC, 3'b111, 9'h004, 16'h0000, 16'h0000, 1'b0);
    #0.5;
    chk1("halt_taken", bus.taken, 1'b0);

    // Asynchronous reset out of HALT, mid-cycle
    #1.5 rst_n = 1'b0;
    #1;
    chk16("arst_pc", bus.pc, 16'h0000);
    chk1("arst_halted", bus.halted, 1'b0);
    chk3("arst_flags", bus.flags, 3'b000);
    drive(1'b0, 4'h0, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0);
    tick();
    @(negedge clk) rst_n = 1'b1;

    // PC wrap: FFFE + 2 and a negative offset below 0000
    drive(1'b1, 4'hD, 3'b111, 9'h000, 16'hFFFE, 16'h0000, 1'b0);
    tick();
    chk16("wrap_br_pc", bus.pc, 16'hFFFE);
    drive(1'b1, 4'h0, 3'b000, 9'h000, 16'h0000, 16'h0001, 1'b0);
    tick();
    chk16("wrap_add_pc", bus.pc, 16'h0000);
    drive(1'b1, 4'hC, 3'b111, 9'h1FE, 16'h0000, 16'h0000, 1'b0);
    tick();
    chk16("wrap_bneg_pc", bus.pc, 16'hFFFE);
    drive(1'b1, 4'h0, 3'b000, 9'h000, 16'h0000, 16'h8000, 1'b0);
    tick();
    chk16("wrap_add2_pc", bus.pc, 16'h0000);
    chk3("wrap_add2_flags", bus.flags, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
